// File: rtl/seg7_pkg.sv
// Glyph constants and nibble-to-segment lookup for the multiplexed 7-segment driver.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable (constants and a pure function only).
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; bit 0 drives segment a.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h7C;
    localparam logic [6:0] SEG_C    = 7'h39;
    localparam logic [6:0] SEG_D    = 7'h5E;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // In BCD mode a nibble above 9 is not a digit, so it shows a dash instead of a letter.
    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] g;
        case (nibble)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        if (!hex_mode && (nibble > 4'd9)) begin
            g = SEG_DASH;
        end
        return g;
    endfunction

endpackage

// File: rtl/bcd_7seg_mux_if.sv
// Value-source to display-driver bundle: load strobe with digit word in, pad-level scan outputs back.
// Latency: wires only.
// Backpressure: none; the driver accepts a load on any cycle and the last load wins.
interface bcd_7seg_mux_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    hex_mode;
    logic                    blank_lz;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [N_DIGITS-1:0]     dig_sel;
    logic                    upd_pend;

    modport master (
        output load, digits_in, dp_in, hex_mode, blank_lz,
        input  seg_out, dp_out, dig_sel, upd_pend
    );

    modport slave (
        input  load, digits_in, dp_in, hex_mode, blank_lz,
        output seg_out, dp_out, dig_sel, upd_pend
    );
endinterface

// File: rtl/seg7_decode.sv
// Single-digit glyph decoder shared by all scan slots via the digit-index mux.
// Latency: combinational.
// Backpressure: not applicable.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Blanking wins over the glyph; polarity is applied later at the output register.
    assign glyph = blank ? SEG_OFF : nibble_to_seg(nibble, hex_mode);

endmodule

// File: rtl/bcd_7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous updates (no tearing).
// Latency: 1 clk from prescaler tick to pins; a load becomes visible at the next frame boundary.
// Backpressure: none; loads are always accepted into the pending regs, a later load overwrites.
module bcd_7seg_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_DIG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    bcd_7seg_mux_if.slave    bus
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [6:0]          SEG_INV = {7{ACTIVE_LOW_SEG}};
    localparam logic [N_DIGITS-1:0] DIG_INV = {N_DIGITS{ACTIVE_LOW_DIG}};

    logic [CNT_W-1:0]        cnt;
    logic                    tick;
    logic [IDX_W-1:0]        idx;
    logic                    boundary;
    logic                    take;

    logic                    pending;
    logic [4*N_DIGITS-1:0]   pend_digits;
    logic [N_DIGITS-1:0]     pend_dp;
    logic                    pend_hex;
    logic                    pend_blz;

    logic [4*N_DIGITS-1:0]   disp_digits;
    logic [N_DIGITS-1:0]     disp_dp;
    logic                    disp_hex;
    logic                    disp_blz;

    logic [4*N_DIGITS-1:0]   frame_digits;
    logic [N_DIGITS-1:0]     frame_dp;
    logic                    frame_hex;
    logic                    frame_blz;

    logic [3:0]              nib [N_DIGITS];
    logic [N_DIGITS-1:0]     lz_mask;
    logic [N_DIGITS-1:0]     dig_onehot;
    logic [6:0]              glyph;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [N_DIGITS-1:0]     dig_q;

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary = tick && (idx == '0);
    assign take     = boundary && pending;

    // At the boundary tick digit 0 must already come from the new data, so bypass the display regs.
    assign frame_digits = take ? pend_digits : disp_digits;
    assign frame_dp     = take ? pend_dp     : disp_dp;
    assign frame_hex    = take ? pend_hex    : disp_hex;
    assign frame_blz    = take ? pend_blz    : disp_blz;

    // Prescaler: one tick every REFRESH_DIV cycles, starting from 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Scan index advances after each tick so the first tick after reset shows digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == IDX_W'(N_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Pending side: a load always lands here; a load on the boundary tick keeps pending set for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_hex    <= 1'b0;
            pend_blz    <= 1'b0;
        end else if (bus.load) begin
            pending     <= 1'b1;
            pend_digits <= bus.digits_in;
            pend_dp     <= bus.dp_in;
            pend_hex    <= bus.hex_mode;
            pend_blz    <= bus.blank_lz;
        end else if (boundary) begin
            pending     <= 1'b0;
        end
    end

    // Display side: only refreshed at a frame boundary, so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_hex    <= 1'b0;
            disp_blz    <= 1'b0;
        end else if (take) begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            disp_hex    <= pend_hex;
            disp_blz    <= pend_blz;
        end
    end

    // Split the digit word into nibbles for the index mux.
    always_comb begin
        for (int k = 0; k < N_DIGITS; k++) begin
            nib[k] = frame_digits[4*k +: 4];
        end
    end

    // Leading-zero mask: digit k is a leading zero if it and every more significant nibble are zero; digit 0 never is.
    always_comb begin
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (nib[k] == 4'd0);
            lz_mask[k] = all_zero;
        end
    end

    // One-hot select for the digit about to be shown.
    always_comb begin
        dig_onehot      = '0;
        dig_onehot[idx] = 1'b1;
    end

    seg7_decode u_decode (
        .nibble   (nib[idx]),
        .hex_mode (frame_hex),
        .blank    (frame_blz && lz_mask[idx]),
        .glyph    (glyph)
    );

    // Output register: reset parks the pins at the off level; each tick loads the current digit with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_OFF ^ SEG_INV;
            dp_q  <= ACTIVE_LOW_SEG;
            dig_q <= DIG_INV;
        end else if (tick) begin
            seg_q <= glyph ^ SEG_INV;
            dp_q  <= frame_dp[idx] ^ ACTIVE_LOW_SEG;
            dig_q <= dig_onehot ^ DIG_INV;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.dp_out   = dp_q;
    assign bus.dig_sel  = dig_q;
    assign bus.upd_pend = pending;

endmodule
